// File: rtl/codec_intf.sv
// codec_intf: CS4272 serial link -- clock generation, CODEC reset, SDout capture, SDin playback.
// Define CODEC_LOOPBACK_EN to replay captured samples on SDin instead of lft_out/rht_out.
module codec_intf (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] lft_out,
  input  logic [15:0] rht_out,
  output logic [15:0] lft_in,
  output logic [15:0] rht_in,
  output logic        valid,
  output logic        MCLK,
  output logic        SCLK,
  output logic        LRCLK,
  output logic        RSTn,
  input  logic        SDout,
  output logic        SDin
);

  logic [9:0]  cnt_r;
  logic [15:0] rx_shift_r;
  logic [15:0] lft_shadow_r;
  logic [15:0] lft_in_r;
  logic [15:0] rht_in_r;
  logic        valid_r;
  logic [15:0] tx_lft_r;
  logic [15:0] tx_rht_r;
  logic        sdin_r;
  logic        rstn_r;
  logic        primed_r;

  logic [9:0]  cnt_nxt_s;
  logic        rx_edge_s;
  logic        tx_edge_s;
  logic        lft_end_s;
  logic        frm_rx_end_s;
  logic        frm_end_s;
  logic [15:0] rx_word_s;
  logic [3:0]  tx_idx_s;
  logic        tx_bit_s;
  logic [15:0] tx_src_lft_s;
  logic [15:0] tx_src_rht_s;

  // Frame position decode: bit-clock edges, half-frame landmarks and next SDin bit.
  always_comb begin
    cnt_nxt_s = cnt_r + 10'd1;
    rx_edge_s = 1'b0;
    tx_edge_s = 1'b0;
    case (cnt_r[4:0])
      5'd15: begin
        rx_edge_s = 1'b1;
        tx_edge_s = 1'b0;
      end
      5'd31: begin
        rx_edge_s = 1'b0;
        tx_edge_s = 1'b1;
      end
      default: begin
        rx_edge_s = 1'b0;
        tx_edge_s = 1'b0;
      end
    endcase
    lft_end_s    = (cnt_r == 10'h1EF);
    frm_rx_end_s = (cnt_r == 10'h3EF);
    frm_end_s    = (cnt_r == 10'h3FF);
    rx_word_s    = {rx_shift_r[14:0], SDout};
    // SDin leads by one clk: the bit shown after this edge belongs to slot cnt+1.
    tx_idx_s     = ~cnt_nxt_s[8:5];
    if (cnt_nxt_s[9]) begin
      tx_bit_s = tx_rht_r[tx_idx_s];
    end else begin
      tx_bit_s = tx_lft_r[tx_idx_s];
    end
  end

`ifdef CODEC_LOOPBACK_EN
  logic unused_eq_s;
  assign unused_eq_s  = ^{lft_out, rht_out};
  assign tx_src_lft_s = lft_in_r;
  assign tx_src_rht_s = rht_in_r;
`else
  assign tx_src_lft_s = lft_out;
  assign tx_src_rht_s = rht_out;
`endif

  // Free-running frame counter; all CODEC clocks are taken from its bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 10'd0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // CODEC reset release after the first frame, then arm capture one frame later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rstn_r   <= 1'b0;
      primed_r <= 1'b0;
    end else if (frm_end_s) begin
      rstn_r   <= 1'b1;
      primed_r <= primed_r | rstn_r;
    end else begin
      rstn_r   <= rstn_r;
      primed_r <= primed_r;
    end
  end

  // SDout deserializer, MSB first, sampled at SCLK rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift_r   <= 16'd0;
      lft_shadow_r <= 16'd0;
    end else begin
      if (rx_edge_s) begin
        rx_shift_r <= rx_word_s;
      end else begin
        rx_shift_r <= rx_shift_r;
      end
      if (lft_end_s) begin
        lft_shadow_r <= rx_word_s;
      end else begin
        lft_shadow_r <= lft_shadow_r;
      end
    end
  end

  // Parallel sample outputs and one-clk valid strobe at the end of each captured frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_in_r <= 16'd0;
      rht_in_r <= 16'd0;
      valid_r  <= 1'b0;
    end else if (frm_rx_end_s && primed_r) begin
      lft_in_r <= lft_shadow_r;
      rht_in_r <= rx_word_s;
      valid_r  <= 1'b1;
    end else begin
      lft_in_r <= lft_in_r;
      rht_in_r <= rht_in_r;
      valid_r  <= 1'b0;
    end
  end

  // Playback holding registers, loaded only in the valid cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_lft_r <= 16'd0;
      tx_rht_r <= 16'd0;
    end else if (valid_r) begin
      tx_lft_r <= tx_src_lft_s;
      tx_rht_r <= tx_src_rht_s;
    end else begin
      tx_lft_r <= tx_lft_r;
      tx_rht_r <= tx_rht_r;
    end
  end

  // SDin serializer, updated at SCLK fall so each bit is settled at the next rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sdin_r <= 1'b0;
    end else if (tx_edge_s) begin
      sdin_r <= tx_bit_s;
    end else begin
      sdin_r <= sdin_r;
    end
  end

  assign MCLK   = cnt_r[1];
  assign SCLK   = cnt_r[4];
  assign LRCLK  = ~cnt_r[9];
  assign RSTn   = rstn_r;
  assign SDin   = sdin_r;
  assign lft_in = lft_in_r;
  assign rht_in = rht_in_r;
  assign valid  = valid_r;

endmodule

// File: tb/tb_codec_intf.sv
// tb_codec_intf: directed CODEC model driving SDout, scoreboard queues for captured samples and SDin frames.
module tb_codec_intf;

  logic        clk;
  logic        rst;
  logic [15:0] lft_out;
  logic [15:0] rht_out;
  logic [15:0] lft_in;
  logic [15:0] rht_in;
  logic        valid;
  logic        MCLK;
  logic        SCLK;
  logic        LRCLK;
  logic        RSTn;
  logic        SDout;
  logic        SDin;

  codec_intf dut (
    .clk     (clk),
    .rst     (rst),
    .lft_out (lft_out),
    .rht_out (rht_out),
    .lft_in  (lft_in),
    .rht_in  (rht_in),
    .valid   (valid),
    .MCLK    (MCLK),
    .SCLK    (SCLK),
    .LRCLK   (LRCLK),
    .RSTn    (RSTn),
    .SDout   (SDout),
    .SDin    (SDin)
  );

  typedef struct {
    int          rel;
    logic [15:0] l;
    logic [15:0] r;
  } rx_exp_t;

  typedef struct {
    int          frame;
    logic [15:0] l;
    logic [15:0] r;
  } tx_exp_t;

  rx_exp_t rx_q[$];
  tx_exp_t tx_q[$];

  // position of the current cycle relative to reset release; mode 0 = in reset, 1 = running, 2 = idle
  int          rel;
  int          frame;
  int          p;
  int          mode;
  int          done;
  logic [15:0] src_l;
  logic [15:0] src_r;

  int checks;
  int errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic load_frame(input int ph, input int f);
    if (ph == 0) begin
      case (f)
        4: begin src_l = 16'h8000; src_r = 16'h7FFF; lft_out = 16'h5A5A; rht_out = 16'h0F0F; end
        5: begin src_l = 16'h0001; src_r = 16'hFFFE; lft_out = 16'h1357; rht_out = 16'hFDB9; end
        6: begin src_l = 16'h5555; src_r = 16'hAAAA; lft_out = 16'h2468; rht_out = 16'hECA8; end
        default: begin src_l = 16'h1234; src_r = 16'hABCD; lft_out = 16'h8001; rht_out = 16'h7FFE; end
      endcase
    end else begin
      src_l = 16'h00FF; src_r = 16'hFF00; lft_out = 16'hC3C3; rht_out = 16'h3C3C;
    end
  endtask

  task automatic reset_cycles(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mode = 0;
      if (i == 0) begin
        rx_q.delete();
        tx_q.delete();
      end
    end
  endtask

  task automatic run_phase(input int ph, input int ncyc, input int nfr);
    logic [9:0]  pv;
    logic [15:0] sd_word;
    rx_exp_t     re;
    tx_exp_t     te;
    for (int r = 0; r < ncyc; r++) begin
      @(negedge clk);
      rst   = 1'b0;
      rel   = r;
      frame = r / 1024;
      p     = r % 1024;
      mode  = 1;
      pv    = p[9:0];
      if (pv == 10'h000) load_frame(ph, frame);
      // equalizer result changes right after the valid edge; must not reach SDin
      if (ph == 0 && frame == 4 && pv > 10'h3F0) begin
        lft_out = 16'hFFFF;
        rht_out = 16'h0000;
      end
      sd_word = pv[9] ? src_r : src_l;
      SDout   = sd_word[4'd15 - pv[8:5]];
      if (pv == 10'h3EF && frame >= 2) begin
        re.rel = r + 1; re.l = src_l; re.r = src_r;
        rx_q.push_back(re);
      end
      if (pv == 10'h3F0 && frame >= 2 && frame + 1 < nfr) begin
        te.frame = frame + 1;
`ifdef CODEC_LOOPBACK_EN
        te.l = src_l; te.r = src_r;
`else
        te.l = lft_out; te.r = rht_out;
`endif
        tx_q.push_back(te);
      end
    end
  endtask

  initial begin
    rst = 1'b1; SDout = 1'b0; lft_out = 16'h0000; rht_out = 16'h0000;
    src_l = 16'h0000; src_r = 16'h0000;
    mode = 2; done = 0; rel = 0; frame = 0; p = 0;
    reset_cycles(3);
    run_phase(0, 6 * 1024 + 16'h250 + 1, 6);
    reset_cycles(3);
    run_phase(1, 4 * 1024, 4);
    @(negedge clk);
    mode = 2;
    done = 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (rel %0d)", name, act, exp, rel);
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [9:0]  pv;
    logic [15:0] col_l;
    logic [15:0] col_r;
    int          loaded;
    int          rstn_rise;
    int          first_valid;
    rx_exp_t     re;
    tx_exp_t     te;
    checks = 0; errors = 0; loaded = 0; rstn_rise = -1; first_valid = 1;
    col_l = 16'h0000; col_r = 16'h0000;
    forever begin
      @(negedge clk);
      #1;
      if (done != 0) begin
        check("rx_queue_drained", rx_q.size(), 0);
        check("tx_queue_drained", tx_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end else if (mode == 0) begin
        check("reset_outputs", {lft_in, rht_in, valid, MCLK, SCLK, LRCLK, RSTn, SDin},
              {16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        loaded = 0; rstn_rise = -1; first_valid = 1;
      end else if (mode == 1) begin
        pv = p[9:0];
        check("clocks_rstn", {MCLK, SCLK, LRCLK, RSTn}, {pv[1], pv[4], ~pv[9], (frame >= 1)});
        if (RSTn === 1'b1 && rstn_rise < 0) rstn_rise = rel;
        if (rx_q.size() > 0 && rx_q[0].rel == rel) begin
          re = rx_q.pop_front();
          check("valid_strobe", valid, 1'b1);
          check("lft_in", lft_in, re.l);
          check("rht_in", rht_in, re.r);
          if (first_valid != 0) begin
            check("rstn_rise_to_valid", rel - rstn_rise, 2032);
            first_valid = 0;
          end
        end else begin
          check("valid_idle", valid, 1'b0);
        end
        if (pv[4:0] == 5'd16) begin
          if (pv[9]) col_r[4'd15 - pv[8:5]] = SDin;
          else       col_l[4'd15 - pv[8:5]] = SDin;
        end
        if (pv == 10'h3FF) begin
          if (tx_q.size() > 0 && tx_q[0].frame == frame) begin
            te = tx_q.pop_front();
            check("sdin_left_slot", col_l, te.l);
            check("sdin_right_slot", col_r, te.r);
            loaded = 1;
          end else if (loaded == 0) begin
            check("sdin_left_idle", col_l, 16'h0000);
            check("sdin_right_idle", col_r, 16'h0000);
          end
        end
      end
    end
  end

endmodule
